// File: rtl/bidir_bus_arbiter_pkg.sv
// ============================================================================
// Module      : bidir_arb_pkg
// Description : Shared types and constants for the bidirectional bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bidir_arb_pkg;

  // Arbiter phases: no owner, dead time before a direction flip, bus owned
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_e;

  // Buffer direction encoding (the value driven on ctrl)
  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  // Counter widths: TURN_CYCLES fits in 4 bits, burst saturates at 255
  localparam int TURN_W  = 4;
  localparam int BURST_W = 8;

  // Request of the side that drives in direction dir
  function automatic logic side_req(input logic dir, input logic req_a,
                                    input logic req_b);
    return (dir == DIR_A2B) ? req_a : req_b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bidir_bus_arbiter_if.sv
// ============================================================================
// Module      : bidir_bus_arbiter_if
// Description : Request/grant and buffer-control bundle between the arbiter
//               (master modport) and the agents/buffer (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bidir_bus_arbiter_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic ctrl;
  logic oe;
  logic turnaround;

  modport master (
    input  req_a, req_b,
    output gnt_a, gnt_b, ctrl, oe, turnaround
  );

  modport slave (
    output req_a, req_b,
    input  gnt_a, gnt_b, ctrl, oe, turnaround
  );
endinterface

`default_nettype wire

// File: rtl/bidir_bus_arbiter_turn_timer.sv
// ============================================================================
// Module      : bidir_turn_timer
// Description : Loadable down-counter timing the dead cycles of a direction
//               change. done_o is high in the last counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_turn_timer
  import bidir_arb_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load_i,
  input  wire logic [TURN_W-1:0] load_val_i,
  output logic                   done_o
);

  logic [TURN_W-1:0] count_q;

  // Load while armed, otherwise count down to zero and stop
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - TURN_W'(1);
    end
  end

  assign done_o = !load_i && (count_q == TURN_W'(1));

endmodule

`default_nettype wire

// File: rtl/bidir_bus_arbiter.sv
// ============================================================================
// Module      : bidir_bus_arbiter
// Description : Round-robin arbiter for a half-duplex link between side A and
//               side B, with burst preemption and turnaround dead cycles.
//               Define BIDIR_ARB_STATS_EN to add turn_count/preempt_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_bus_arbiter
  import bidir_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  bidir_bus_arbiter_if.master bus
`ifdef BIDIR_ARB_STATS_EN
  ,
  output logic [15:0]         turn_count,
  output logic [7:0]          preempt_count
`endif
);

  state_e             state_q;
  logic               gnt_a_q;
  logic               gnt_b_q;
  logic               oe_q;
  logic               turn_q;
  logic               ctrl_q;
  logic               last_q;   // direction granted most recently
  logic [BURST_W-1:0] burst_q;

  logic owner_req;
  logic other_req;
  logic idle_winner;
  logic burst_hit;
  logic timer_done;

  // In OWN and TURN the owner / latched winner is always the side ctrl points at
  assign owner_req = side_req(ctrl_q, bus.req_a, bus.req_b);
  assign other_req = side_req(~ctrl_q, bus.req_a, bus.req_b);
  assign burst_hit = (burst_q >= BURST_W'(MAX_BURST));

  // Sole requester wins; on a tie the side not granted last wins
  assign idle_winner = (bus.req_a && bus.req_b) ? ~last_q :
                       (bus.req_a ? DIR_A2B : DIR_B2A);

  // Timer stays armed outside TURN so it holds TURN_CYCLES on TURN entry
  bidir_turn_timer u_turn_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q != TURN),
    .load_val_i (TURN_W'(TURN_CYCLES)),
    .done_o     (timer_done)
  );

  // Arbitration FSM with registered grant, enable and direction outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      oe_q    <= 1'b0;
      turn_q  <= 1'b0;
      ctrl_q  <= DIR_B2A;
      last_q  <= DIR_B2A;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            if (idle_winner == ctrl_q) begin
              state_q <= OWN;
              gnt_a_q <= (idle_winner == DIR_A2B);
              gnt_b_q <= (idle_winner == DIR_B2A);
              oe_q    <= 1'b1;
              last_q  <= idle_winner;
              burst_q <= BURST_W'(1);
            end else begin
              state_q <= TURN;
              ctrl_q  <= idle_winner;
              turn_q  <= 1'b1;
            end
          end
        end
        TURN: begin
          if (timer_done) begin
            turn_q <= 1'b0;
            if (owner_req) begin
              state_q <= OWN;
              gnt_a_q <= (ctrl_q == DIR_A2B);
              gnt_b_q <= (ctrl_q == DIR_B2A);
              oe_q    <= 1'b1;
              last_q  <= ctrl_q;
              burst_q <= BURST_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OWN: begin
          if (!owner_req || (burst_hit && other_req)) begin
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            oe_q    <= 1'b0;
            if (other_req) begin
              state_q <= TURN;
              ctrl_q  <= ~ctrl_q;
              turn_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (burst_q != '1) begin
            burst_q <= burst_q + BURST_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.oe         = oe_q;
  assign bus.turnaround = turn_q;
  assign bus.ctrl       = ctrl_q;

`ifdef BIDIR_ARB_STATS_EN
  logic [15:0] turn_cnt_q;
  logic [7:0]  preempt_cnt_q;

  // Saturating counts of completed dead-time sequences and forced releases
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt_q    <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (state_q == TURN && timer_done && turn_cnt_q != '1) begin
        turn_cnt_q <= turn_cnt_q + 16'd1;
      end
      if (state_q == OWN && owner_req && burst_hit && other_req &&
          preempt_cnt_q != '1) begin
        preempt_cnt_q <= preempt_cnt_q + 8'd1;
      end
    end
  end

  assign turn_count    = turn_cnt_q;
  assign preempt_count = preempt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_arbiter.sv
// ============================================================================
// Module      : tb_bidir_bus_arbiter
// Description : Self-checking bench for bidir_bus_arbiter: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bidir_bus_arbiter;

  localparam int TC = 2;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bidir_bus_arbiter_if bus ();

`ifdef BIDIR_ARB_STATS_EN
  logic [15:0] turn_count;
  logic [7:0]  preempt_count;
`endif

  bidir_bus_arbiter #(
    .TURN_CYCLES (TC),
    .MAX_BURST   (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BIDIR_ARB_STATS_EN
    ,
    .turn_count    (turn_count),
    .preempt_count (preempt_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 none, 1 side A, 0 side B. Direction value equals side code.
  int  m_owner = -1;
  int  m_dead  = 0;
  int  m_pend  = 0;
  int  m_burst = 0;
  int  m_last  = 0;
  int  m_dir   = 0;
  int  m_tcnt  = 0;
  int  m_pcnt  = 0;
  bit  m_valid = 1'b0;

  function automatic bit rq(input int s, input logic ra, input logic rb);
    return (s == 1) ? bit'(ra) : bit'(rb);
  endfunction

  task automatic m_grant(input int s);
    m_owner = s;
    m_burst = 1;
    m_last  = s;
  endtask

  task automatic m_start_turn(input int s);
    m_dir  = s;
    m_dead = TC;
    m_pend = s;
  endtask

  task automatic model_step(input logic r, input logic ra, input logic rb);
    int o;
    int w;
    if (r) begin
      m_owner = -1; m_dead = 0; m_dir = 0; m_last = 0; m_burst = 0;
      m_tcnt = 0; m_pcnt = 0; m_valid = 1'b1;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        if (m_tcnt < 65535) m_tcnt++;
        if (rq(m_pend, ra, rb)) m_grant(m_pend);
        else m_owner = -1;
      end
    end else if (m_owner >= 0) begin
      o = m_owner;
      if (!rq(o, ra, rb) || (m_burst >= MB && rq(1 - o, ra, rb))) begin
        if (rq(o, ra, rb) && m_pcnt < 255) m_pcnt++;
        m_owner = -1;
        if (rq(1 - o, ra, rb)) m_start_turn(1 - o);
      end else if (m_burst < 255) begin
        m_burst++;
      end
    end else if (ra || rb) begin
      if (ra && rb) w = 1 - m_last;
      else w = ra ? 1 : 0;
      if (w == m_dir) m_grant(w);
      else m_start_turn(w);
    end
  endtask

  // Compare outputs produced by the last rising edge, then advance the model
  // with the inputs the next rising edge will sample
  always @(negedge clk) begin
    if (m_valid) begin
      check("outputs{gnt_a,gnt_b,oe,turn,ctrl}",
            {bus.gnt_a, bus.gnt_b, bus.oe, bus.turnaround, bus.ctrl},
            {(m_owner == 1), (m_owner == 0), (m_owner >= 0), (m_dead > 0),
             m_dir[0]});
      check("exclusion", {(bus.gnt_a && bus.gnt_b), (bus.oe && bus.turnaround)},
            2'b00);
`ifdef BIDIR_ARB_STATS_EN
      check("turn_count", turn_count, m_tcnt);
      check("preempt_count", preempt_count, m_pcnt);
`endif
    end
    model_step(rst, bus.req_a, bus.req_b);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("reset{gnt_a,gnt_b,oe,turn,ctrl}",
          {bus.gnt_a, bus.gnt_b, bus.oe, bus.turnaround, bus.ctrl}, 5'b00000);

    // A requests from reset: two dead cycles then grant
    rst = 1'b0;
    bus.req_a = 1'b1;
    step();
    check("turn1{gnt_a,oe,turn,ctrl}", {bus.gnt_a, bus.oe, bus.turnaround, bus.ctrl}, 4'b0011);
    step();
    check("turn2{gnt_a,oe,turn,ctrl}", {bus.gnt_a, bus.oe, bus.turnaround, bus.ctrl}, 4'b0011);
    step();
    check("grantA{gnt_a,oe,turn,ctrl}", {bus.gnt_a, bus.oe, bus.turnaround, bus.ctrl}, 4'b1101);

    // Same-direction re-request: no turnaround
    bus.req_a = 1'b0;
    step();
    check("dropA{gnt_a,oe,ctrl}", {bus.gnt_a, bus.oe, bus.ctrl}, 3'b001);
    bus.req_a = 1'b1;
    step();
    check("regrantA{gnt_a,oe,turn}", {bus.gnt_a, bus.oe, bus.turnaround}, 3'b110);

    // Both request from reset: A first, preempted after MB grant cycles
    rst = 1'b1;
    bus.req_a = 1'b0;
    step();
    rst = 1'b0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (bus.gnt_a) cnt++;
      if (k == 1)  check("both_turn{turn,ctrl}", {bus.turnaround, bus.ctrl}, 2'b11);
      if (k == 3)  check("both_grantA", bus.gnt_a, 1'b1);
      if (k == 18) check("lastA{gnt_a,gnt_b}", {bus.gnt_a, bus.gnt_b}, 2'b10);
      if (k == 19) check("preempt{gnt_a,turn,ctrl}", {bus.gnt_a, bus.turnaround, bus.ctrl}, 3'b010);
      if (k == 21) check("grantB{gnt_b,oe,ctrl}", {bus.gnt_b, bus.oe, bus.ctrl}, 3'b110);
    end
    check("burst_len_A", cnt, MB);

    // B holds with A idle: no preemption
    bus.req_a = 1'b0;
    cnt = 0;
    repeat (100) begin
      step();
      if (bus.gnt_b) cnt++;
    end
    check("B_hold_100", cnt, 100);

    // One-cycle B pulse from IDLE with ctrl=1: turn completes, no grant
    rst = 1'b1;
    bus.req_b = 1'b0;
    step();
    rst = 1'b0;
    bus.req_a = 1'b1;
    repeat (4) step();
    bus.req_a = 1'b0;
    step();
    check("idle_ctrlA{gnt_a,oe,ctrl}", {bus.gnt_a, bus.oe, bus.ctrl}, 3'b001);
    bus.req_b = 1'b1;
    step();
    check("pulse_turn{turn,ctrl}", {bus.turnaround, bus.ctrl}, 2'b10);
    bus.req_b = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (bus.gnt_b) seen = 1'b1;
    end
    check("pulse_no_grant{seen_gnt_b,turn}", {seen, bus.turnaround}, 2'b00);

    // Reset mid-TURN and mid-OWN
    bus.req_a = 1'b1;
    step();
    check("midturn{turn,ctrl}", {bus.turnaround, bus.ctrl}, 2'b11);
    rst = 1'b1;
    step();
    check("rst_turn_all", {bus.gnt_a, bus.gnt_b, bus.oe, bus.turnaround, bus.ctrl}, 5'b00000);
    rst = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    step();
    check("directB{gnt_b,oe,turn}", {bus.gnt_b, bus.oe, bus.turnaround}, 3'b110);
    rst = 1'b1;
    step();
    check("rst_own_all", {bus.gnt_a, bus.gnt_b, bus.oe, bus.turnaround, bus.ctrl}, 5'b00000);

    // Three direction flips
    rst = 1'b0;
    bus.req_b = 1'b0;
    bus.req_a = 1'b1;
    repeat (4) step();
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    repeat (4) step();
    bus.req_b = 1'b0;
    bus.req_a = 1'b1;
    repeat (4) step();
    check("flip3_grantA", {bus.gnt_a, bus.ctrl}, 2'b11);
`ifdef BIDIR_ARB_STATS_EN
    check("turn_count_3", turn_count, 16'd3);
`endif

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(0, 7) == 0) bus.req_b = ~bus.req_b;
      step();
    end

    rst = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bidir_bus_arbiter.md
Name: bidir_bus_arbiter

Overview:
- Arbitrates the shared half-duplex link between side A and side B for the bidirectional buffer; drives its direction control and a bus output-enable.
- Grants one side at a time using a req/gnt handshake, with round-robin fairness and a burst limit.
- Inserts dead (turnaround) cycles whenever the direction flips, so both sides never drive the link at once.
- Sits between the two requesting agents and the tristate buffer pair.

Parameters:
- TURN_CYCLES, 2, dead cycles inserted on a direction change; legal range 1..15.
- MAX_BURST, 16, granted cycles after which the owner is preempted if the other side is waiting; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  side A requests to drive A->B; held high while it wants the bus.
- req_b  input  1  side B requests to drive B->A.
- gnt_a  output  1  A owns the bus.
- gnt_b  output  1  B owns the bus.
- ctrl  output  1  buffer direction: 1 = A drives B, 0 = B drives A.
- oe  output  1  buffer enable; high only while a grant is active.
- turnaround  output  1  high during dead cycles.

Behaviour:
- All outputs are registered. Reset values: gnt_a=0, gnt_b=0, oe=0, turnaround=0, ctrl=0; round-robin pointer favours A.
- States:
  - IDLE: no owner. Sample requests each cycle. Winner: the sole requester; if both request, the side not granted last (A after reset).
    - Winner's direction equals current ctrl: go to OWN next edge; gnt and oe rise at that edge, 1-cycle latency.
    - Direction differs: go to TURN; ctrl updates at that edge, oe=0, turnaround=1.
  - TURN: down-counter loaded with TURN_CYCLES. In TURN for exactly TURN_CYCLES cycles, then OWN; grant latency = TURN_CYCLES+1. ctrl holds the new direction throughout. The winner is latched at TURN entry.
    - If the winner drops req during TURN: still complete TURN, then go to IDLE without granting.
  - OWN: gnt and oe high, burst counter increments each cycle, saturating at 255.
    - Owner drops req: gnt and oe fall at the next edge. Go to IDLE, or directly to TURN if the other side is requesting.
    - burst counter >= MAX_BURST and the other side is requesting: force release at the next edge and go to TURN toward the other side, even if the owner's req is still high.
    - Other side idle: the owner may hold indefinitely.
- Pointer update: the round-robin pointer updates on every OWN entry.
- Exclusion: gnt_a and gnt_b are never both high; oe is never high while turnaround is high.
- Reset mid-operation: returns to IDLE within one edge with all outputs at reset values; in-progress burst and turn counts are discarded.
- Simultaneous requests while in OWN: only the non-owner's req matters for preemption.

Optional Feature:
- BIDIR_ARB_STATS_EN defined:
  - Adds output port turn_count[15:0], a saturating count of completed TURN sequences; resets to 0.
  - Adds output port preempt_count[7:0], a saturating count of forced releases; resets to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package bidir_arb_pkg:
  - state enum {IDLE, TURN, OWN}.
  - Constants DIR_A2B=1'b1 and DIR_B2A=1'b0.
  - Counter widths TURN_W=4 and BURST_W=8.
- Sub-module bidir_turn_timer: loadable down-counter with a done pulse, used for TURN dead time.

Test Plan:
- Reset, then req_a=1: TURN for 2 cycles (ctrl=1, oe=0, turnaround=1), then gnt_a=1 and oe=1 at cycle 3.
- A owns; A drops req, then req_a reasserts while ctrl=1: no TURN, gnt_a returns after 1 cycle.
- req_a and req_b both high from reset: A granted first. Hold both: A preempted after 16 grant cycles, 2 dead cycles, then gnt_b=1 with ctrl=0.
- B owns with req_a low for 100 cycles: gnt_b stays high, no preemption.
- req_b pulses 1 cycle from IDLE with ctrl=1: TURN completes, state returns to IDLE, gnt_b never asserts.
- rst asserted mid-TURN and mid-OWN: next edge all outputs 0, ctrl=0. With BIDIR_ARB_STATS_EN, turn_count reads 3 after three direction flips.
